// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : Instruction fetch sequencer. It drives the ROM address, registers
//            the returned word for decode, and runs a single-level hardware loop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
  parameter int A      = 8,
  parameter int W_INST = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [A-1:0]      addr_o,
  input  logic [W_INST-1:0] rom_data_i,
  output logic [W_INST-1:0] inst_o,
  output logic [A-1:0]      inst_pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              jmp_i,
  input  logic [A-1:0]      jmp_addr_i,
  input  logic              loop_set_i,
  input  logic [A-1:0]      loop_start_i,
  input  logic [A-1:0]      loop_end_i,
  input  logic [CNT_W-1:0]  loop_cnt_i,
  input  logic              halt_i,
  input  logic              resume_i,
  output logic              halted_o,
  output logic              loop_active_o
);

  localparam logic [A-1:0]     C_PC_ONE  = A'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [A-1:0]        r_pc;
  logic [W_INST-1:0]   r_inst;
  logic [A-1:0]        r_inst_pc;
  logic                r_valid;
  logic                r_loop_active;
  logic [A-1:0]        r_loop_start;
  logic [A-1:0]        r_loop_end;
  logic [CNT_W-1:0]    r_loop_cnt;

  logic                w_run;
  logic                w_jmp;
  logic                w_adv;
  logic                w_at_end;
  logic                w_wrap;
  logic [A-1:0]        w_next_pc;

  assign w_run     = (r_state == ST_RUN);
  assign w_jmp     = w_run && jmp_i;
  // Halt request blocks the fetch in the same cycle it arrives.
  assign w_adv     = w_run && !jmp_i && !halt_i && (!r_valid || ready_i);
  assign w_at_end  = r_loop_active && (r_pc == r_loop_end);
  assign w_wrap    = w_at_end && (r_loop_cnt != '0);
  assign w_next_pc = w_wrap ? r_loop_start : (r_pc + C_PC_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (halt_i && !jmp_i)    w_state_nxt = ST_HALT;
      ST_HALT: if (resume_i && !halt_i) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_RUN;
      r_pc          <= '0;
      r_inst        <= '0;
      r_inst_pc     <= '0;
      r_valid       <= 1'b0;
      r_loop_active <= 1'b0;
      r_loop_start  <= '0;
      r_loop_end    <= '0;
      r_loop_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_jmp) begin
        r_pc    <= jmp_addr_i;
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_inst    <= rom_data_i;
        r_inst_pc <= r_pc;
        r_valid   <= 1'b1;
        r_pc      <= w_next_pc;
        if (w_at_end) begin
          if (w_wrap) r_loop_cnt    <= r_loop_cnt - C_CNT_ONE;
          else        r_loop_active <= 1'b0;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      // Arming is last so a new loop overrides any bookkeeping above.
      if (loop_set_i) begin
        r_loop_active <= 1'b1;
        r_loop_start  <= loop_start_i;
        r_loop_end    <= loop_end_i;
        r_loop_cnt    <= loop_cnt_i;
      end
    end
  end

  assign addr_o        = r_pc;
  assign inst_o        = r_inst;
  assign inst_pc_o     = r_inst_pc;
  assign valid_o       = r_valid;
  assign halted_o      = (r_state == ST_HALT);
  assign loop_active_o = r_loop_active;

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction fetch sequencer that sits directly upstream of the core's decode/ALU path. It drives the ROM address, registers the returned instruction word, and presents it to decode with a valid/ready handshake. It also owns PC sequencing: linear increment with wrap, jump redirect, a single-level zero-overhead hardware loop, and halt/resume.

Parameters:
A, 8, PC/ROM address width
W_INST, 32, instruction word width
CNT_W, 8, hardware loop counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
addr_o  out  A  ROM address (current PC)
rom_data_i  in  W_INST  ROM read data; combinational from addr_o
inst_o  out  W_INST  registered instruction to decode
inst_pc_o  out  A  address that inst_o was fetched from
valid_o  out  1  inst_o holds a live instruction
ready_i  in  1  decode accepts inst_o this cycle
jmp_i  in  1  redirect fetch (one-cycle pulse)
jmp_addr_i  in  A  jump target
loop_set_i  in  1  arm hardware loop (one-cycle pulse)
loop_start_i  in  A  first address of loop body
loop_end_i  in  A  last address of loop body
loop_cnt_i  in  CNT_W  extra iterations; body runs loop_cnt_i+1 times
halt_i  in  1  stop fetching
resume_i  in  1  leave HALT
halted_o  out  1  in HALT state
loop_active_o  out  1  hardware loop armed

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk_i and rst_i. All state updates on posedge clk_i.
- Reset values: pc=0 (so addr_o=0), inst_o=0, inst_pc_o=0, valid_o=0, halted_o=0, loop_active_o=0, loop count=0, state RUN.
- States:
  - RUN -> HALT on halt_i.
  - HALT -> RUN on resume_i.
  - resume_i in RUN is ignored.
  - halt_i and resume_i together in HALT: stay in HALT.
- addr_o = pc at all times.
- adv = RUN && !jmp_i && (!valid_o || ready_i).
- On adv:
  - inst_o <= rom_data_i, inst_pc_o <= pc, valid_o <= 1, pc <= next_pc.
  - Latency: the word at address X is on inst_o exactly one cycle after addr_o = X.
- Stall: valid_o && !ready_i holds inst_o, inst_pc_o and pc unchanged.
- When ready_i && valid_o and adv is false (HALT or jmp_i), valid_o <= 0.
- next_pc:
  - If loop_active && pc == loop_end && cnt != 0: loop_start, and cnt <= cnt - 1.
  - If loop_active && pc == loop_end && cnt == 0: pc + 1, and loop_active <= 0.
  - Otherwise: pc + 1, modulo 2^A (2^A-1 wraps to 0).
- jmp_i (RUN only; ignored in HALT):
  - pc <= jmp_addr_i and valid_o <= 0 (flush), whether or not ready_i.
  - No fetch that cycle.
  - An armed loop stays armed.
- loop_set_i:
  - Loads start/end/cnt and sets loop_active <= 1, in any state.
  - Overwrites any active loop.
  - Same-cycle loop_set_i and adv: the pc==loop_end check for that cycle uses the old loop registers.
  - loop_set_i with jmp_i: both take effect.
  - loop_start_i == loop_end_i gives a single-instruction loop.
- halt_i:
  - In RUN with halt_i: no fetch that cycle, pc frozen.
  - The current inst_o stays valid until ready_i; then valid_o <= 0.
  - pc is held through HALT.
  - The first adv after resume fetches the held pc.
- Priority: rst_i > jmp_i > halt_i > loop wrap > increment.
- rst_i mid-loop or mid-halt: all state returns to reset values the following cycle.

Test Plan:
- Reset, ready_i=1, ROM[i]=i+0x100 -> addr_o 0,1,2,...; inst_o=0x100 with inst_pc_o=0 one cycle after addr_o=0; valid_o stays high.
- Hold ready_i=0 for 3 cycles at inst_pc_o=2 -> inst_o, inst_pc_o and addr_o=3 are frozen; releasing ready_i resumes with inst_pc_o=3, and no address is skipped or duplicated.
- loop_set_i with start=4, end=6, cnt=2, issued at pc=2 -> inst_pc_o sequence is 2,3,4,5,6,4,5,6,4,5,6,7; loop_active_o clears when pc=6 is fetched the third time.
- jmp_i to 0x20 while valid_o=1 and ready_i=0 -> valid_o=0 next cycle; the next inst_pc_o is 0x20; the previous inst_o is never accepted.
- halt_i at pc=9 -> halted_o=1, no new valid after the pending handshake, addr_o=9 held; resume_i 5 cycles later -> next inst_pc_o=9.
- With A=8, start at pc=0xFE -> inst_pc_o 0xFE,0xFF,0x00; rst_i asserted mid-loop -> addr_o=0, valid_o=0, loop_active_o=0 the next cycle.
